// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-master arbiter in front of a single downstream memory port.
//   One transaction is outstanding at a time: IDLE picks a winner and
//   registers its request onto mem_*, GRANT waits for mem_ack_i (guarded
//   by a watchdog), RESP returns the completion to the winner, and DRAIN
//   swallows the late downstream ack of a transaction that timed out.
//
// Parameters
//   PRIORITY_MODE   0 = round-robin, 1 = fixed priority (m0 wins ties)
//   TIMEOUT_CYCLES  GRANT cycles without mem_ack_i before the watchdog
//                   fires; 0 disables the watchdog
//
// Ports
//   clk, reset_n_i              clock, asynchronous active-low reset
//   mX_sel_i/wr_en_i/wr_mask_i/address_i/data_i   master X request
//   mX_data_o/ack_o/err_o       master X completion (ack is a 1-cycle pulse)
//   mem_sel_o/wr_en_o/wr_mask_o/address_o/data_o  downstream request
//   mem_data_i, mem_ack_i       downstream read data and completion pulse
module sdram_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        m0_sel_i,
  input  logic        m0_wr_en_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [31:0] m0_address_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_sel_i,
  input  logic        m1_wr_en_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m1_address_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        mem_sel_o,
  output logic        mem_wr_en_o,
  output logic [3:0]  mem_wr_mask_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [15:0] wdog;
  logic [15:0] wdog_next;
  logic        last_grant;   // 1 = m1 was granted last
  logic        owner;        // master of the current transaction, 1 = m1
  logic        pick_m1;
  logic        timeout_hit;

  // Winner for a request sampled in IDLE.
  always_comb begin
    pick_m1 = m1_sel_i;
    if (m0_sel_i && m1_sel_i) begin
      if (PRIORITY_MODE == 1) pick_m1 = 1'b0;
      else                    pick_m1 = ~last_grant;
    end
  end

  // The watchdog fires on the edge where the count would reach the limit,
  // so expiry lands TIMEOUT_CYCLES cycles after entering GRANT.
  always_comb begin
    wdog_next   = wdog + 16'd1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_next == 16'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      wdog          <= '0;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      mem_sel_o     <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_mask_o <= '0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      m0_data_o     <= '0;
      m1_data_o     <= '0;
      m0_ack_o      <= 1'b0;
      m1_ack_o      <= 1'b0;
      m0_err_o      <= 1'b0;
      m1_err_o      <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses; only the completing branch sets them.
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_sel_i || m1_sel_i) begin
            owner         <= pick_m1;
            last_grant    <= pick_m1;
            mem_sel_o     <= 1'b1;
            mem_wr_en_o   <= pick_m1 ? m1_wr_en_i   : m0_wr_en_i;
            mem_wr_mask_o <= pick_m1 ? m1_wr_mask_i : m0_wr_mask_i;
            mem_address_o <= pick_m1 ? m1_address_i : m0_address_i;
            mem_data_o    <= pick_m1 ? m1_data_i    : m0_data_i;
            wdog          <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          // A real ack takes precedence over a coincident watchdog expiry.
          if (mem_ack_i) begin
            mem_sel_o <= 1'b0;
            if (owner) begin
              m1_data_o <= mem_data_i;
              m1_ack_o  <= 1'b1;
            end else begin
              m0_data_o <= mem_data_i;
              m0_ack_o  <= 1'b1;
            end
            state <= RESP;
          end else if (timeout_hit) begin
            mem_sel_o <= 1'b0;
            if (owner) begin
              m1_data_o <= '0;
              m1_ack_o  <= 1'b1;
              m1_err_o  <= 1'b1;
            end else begin
              m0_data_o <= '0;
              m0_ack_o  <= 1'b1;
              m0_err_o  <= 1'b1;
            end
            state <= DRAIN;
          end else begin
            wdog <= wdog_next;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (mem_ack_i) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0: 0 = round-robin; 1 = fixed priority with m0 always winning.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: GRANT-cycle limit before the watchdog fires; 0 disables the watchdog; counter width is 16 bits.
REQ-003 The module SHALL use one clock, `clk`; reset is asynchronous and active-low, port `reset_n_i`.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 m0_sel_i, m1_sel_i  in  1  master request, held high until that master's ack.
REQ-007 m0_wr_en_i, m1_wr_en_i  in  1  1 = write, 0 = read.
REQ-008 m0_wr_mask_i, m1_wr_mask_i  in  4  byte write mask.
REQ-009 m0_address_i, m1_address_i  in  32  word address.
REQ-010 m0_data_i, m1_data_i  in  32  write data.
REQ-011 m0_data_o, m1_data_o  out  32  read data, valid while the matching ack is high.
REQ-012 m0_ack_o, m1_ack_o  out  1  one-cycle completion pulse.
REQ-013 m0_err_o, m1_err_o  out  1  timeout flag, valid with ack.
REQ-014 mem_sel_o, mem_wr_en_o  out  1  downstream request and direction.
REQ-015 mem_wr_mask_o  out  4; mem_address_o  out  32; mem_data_o  out  32  downstream request fields.
REQ-016 mem_data_i  in  32; mem_ack_i  in  1  downstream read data and one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, GRANT, RESP and DRAIN; all outputs SHALL be registered.
REQ-018 IDLE: with any sel high, the FSM SHALL latch the winner's wr_en, mask, address and data onto the mem_* outputs, set mem_sel_o=1, and go to GRANT on the next edge.
REQ-019 Round-robin: with both sel high, the master not granted last SHALL win; with one sel high, that master SHALL win.
REQ-020 last_grant SHALL update on every grant.
REQ-021 PRIORITY_MODE=1: m0 SHALL win every tie.
REQ-022 GRANT: mem_* outputs SHALL stay stable; inputs of either master SHALL be ignored.
REQ-023 GRANT with mem_ack_i=1: at that edge mem_sel_o<=0, the granted master's data_o<=mem_data_i, ack_o<=1, err_o<=0, and the FSM SHALL go to RESP.
REQ-024 RESP SHALL last exactly one cycle with mem_sel_o=0, then go to IDLE; this guarantees at least one idle cycle between downstream requests.
REQ-025 Write completion SHALL also capture mem_data_i, whose value is don't-care.
REQ-026 Watchdog: the counter SHALL clear on entering GRANT and increment each GRANT cycle without mem_ack_i.
REQ-027 On the watchdog reaching TIMEOUT_CYCLES: mem_sel_o<=0, the granted master gets ack_o=1, err_o=1, data_o=0, and the FSM SHALL go to DRAIN.
REQ-028 DRAIN SHALL wait for mem_ack_i, discard its data, raise no master ack, and then go to IDLE.
REQ-029 Requests arriving in GRANT, RESP or DRAIN SHALL stay pending and SHALL NOT be lost.
REQ-030 Simultaneous mem_ack_i and watchdog expiry in the same cycle: the ack SHALL win, giving a normal completion.
REQ-031 A non-granted master's ack_o and err_o SHALL stay 0 at all times.
REQ-032 Latency: master ack SHALL occur 1 cycle after mem_ack_i, and mem_sel_o SHALL rise 1 cycle after sel is sampled in IDLE.

Reset
REQ-033 Asserting reset_n_i low SHALL immediately force: FSM=IDLE; mem_sel_o, mem_wr_en_o, all ack_o and err_o = 0; mem_wr_mask_o=0; mem_address_o, mem_data_o, all data_o = 0; watchdog=0; last_grant=m1, so m0 wins the first tie.
REQ-034 Reset mid-GRANT SHALL abandon the transaction with no master ack; a later stray mem_ack_i seen in IDLE SHALL be ignored.

Verification
REQ-035 Single m0 read, address 0x100, mem_ack_i 5 cycles after mem_sel_o with mem_data_i=0xDEADBEEF -> m0_ack_o pulses once, m0_data_o=0xDEADBEEF, m0_err_o=0, mem_sel_o low during RESP.
REQ-036 Both masters request continuously from reset, PRIORITY_MODE=0 -> grant order m0, m1, m0, m1, each separated by one idle cycle with mem_sel_o=0.
REQ-037 Same stimulus with PRIORITY_MODE=1 and m0 re-requesting immediately -> m0 granted each time, m1 granted only when m0_sel_i is low in IDLE.
REQ-038 m1 write, mask 4'b0011, data 0x12345678, TIMEOUT_CYCLES=8, no mem_ack_i -> m1_ack_o and m1_err_o high 8 cycles into GRANT; a late mem_ack_i is absorbed in DRAIN; the next m0 request is served normally.
REQ-039 mem_ack_i asserted in the same cycle the watchdog reaches TIMEOUT_CYCLES -> normal completion, err_o=0, no DRAIN.
REQ-040 reset_n_i pulsed low during GRANT -> all outputs 0 asynchronously; a following mem_ack_i produces no master ack; a fresh request is granted.
